// File: rtl/horner_eval.sv
// Sequential Horner-rule polynomial evaluator: one multiplier and one adder driven by a small FSM.
// Define HORNER_SAT_EN for saturating arithmetic with overflow reporting; otherwise arithmetic wraps and ovf stays 0.
module horner_eval #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2,
    parameter int AW     = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic [WIDTH-1:0] x,
    output logic [AW-1:0]    coef_addr,
    input  logic [WIDTH-1:0] coef_data,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

`ifdef HORNER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [AW-1:0] IDX_TOP  = AW'(DEGREE);
    localparam logic [AW-1:0] IDX_NEXT = AW'((DEGREE > 0) ? DEGREE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_ADD,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   x_r;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      addr_q;
    logic               ovf_int;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic               mul_ovf;
    logic               add_ovf;

    assign prod    = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_r};
    assign sum     = {1'b0, acc} + {1'b0, coef_data};
    assign mul_ovf = |prod[2*WIDTH-1:WIDTH];
    assign add_ovf = sum[WIDTH];
    assign busy    = (state != S_IDLE);

    // Address is driven only where the store is read; elsewhere it holds its last value.
    always_comb begin
        state_nx  = state;
        coef_addr = addr_q;
        case (state)
            S_IDLE: if (w) state_nx = S_LOAD;
            S_LOAD: begin
                coef_addr = IDX_TOP;
                state_nx  = (DEGREE == 0) ? S_DONE : S_MUL;
            end
            S_MUL:  state_nx = S_ADD;
            S_ADD: begin
                coef_addr = idx;
                state_nx  = (idx == '0) ? S_DONE : S_MUL;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            x_r     <= '0;
            idx     <= '0;
            addr_q  <= '0;
            ovf_int <= 1'b0;
            y       <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_q <= coef_addr;
            done   <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (w) begin
                        x_r <= x;
                        idx <= IDX_TOP;
                    end
                end
                S_LOAD: begin
                    acc     <= coef_data;
                    ovf_int <= 1'b0;
                    if (DEGREE != 0) idx <= IDX_NEXT;
                end
                S_MUL: begin
                    acc <= (SAT_EN && mul_ovf) ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
                    if (mul_ovf) ovf_int <= 1'b1;
                end
                S_ADD: begin
                    acc <= (SAT_EN && add_ovf) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                    if (add_ovf) ovf_int <= 1'b1;
                    if (idx != '0) idx <= idx - 1'b1;
                end
                S_DONE: begin
                    y   <= acc;
                    ovf <= SAT_EN & ovf_int;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_horner_eval.sv
// Bench for horner_eval: a DEGREE=2 instance checked through a scoreboard, plus a DEGREE=0 instance.
// Expected y/ovf follow HORNER_SAT_EN when the macro is defined for the build.
module tb_horner_eval;
    localparam int W = 8;

`ifdef HORNER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         w, w0;
    logic [W-1:0] x, x0;
    logic [1:0]   coef_addr;
    logic [W-1:0] coef_data, y;
    logic         busy, done, ovf;
    logic [0:0]   coef_addr0;
    logic [W-1:0] coef_data0, y0;
    logic         busy0, done0, ovf0;
    logic [W-1:0] coef [0:2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_ovf_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] mon_y;
    logic         mon_o;

    always #5 clk = ~clk;

    assign coef_data  = (coef_addr <= 2'd2) ? coef[coef_addr] : '0;
    assign coef_data0 = (coef_addr0 == 1'b0) ? 8'h7A : 8'h00;

    horner_eval #(.WIDTH(W), .DEGREE(2)) dut (
        .clk(clk), .rst(rst), .w(w), .x(x),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .y(y), .busy(busy), .done(done), .ovf(ovf)
    );

    horner_eval #(.WIDTH(W), .DEGREE(0)) dut0 (
        .clk(clk), .rst(rst), .w(w0), .x(x0),
        .coef_addr(coef_addr0), .coef_data(coef_data0),
        .y(y0), .busy(busy0), .done(done0), .ovf(ovf0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference evaluation at full precision, deciding overflow per step.
    function automatic logic [W-1:0] model_eval(input logic [W-1:0] xv, output logic o);
        int a, t;
        a = int'(coef[2]);
        o = 1'b0;
        for (int i = 1; i >= 0; i--) begin
            t = a * int'(xv);
            if (t > 255) begin o = 1'b1; a = SAT ? 255 : (t % 256); end
            else a = t;
            t = a + int'(coef[i]);
            if (t > 255) begin o = 1'b1; a = SAT ? 255 : (t % 256); end
            else a = t;
        end
        if (!SAT) o = 1'b0;
        return W'(a);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && w && !busy) begin
            mon_y = model_eval(x, mon_o);
            exp_q.push_back(mon_y);
            exp_ovf_q.push_back(mon_o);
            exp_cyc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) check("spurious_done", 1, 0);
            else begin
                check("sb_y", y, exp_q.pop_front());
                check("sb_ovf", ovf, exp_ovf_q.pop_front());
                check("sb_latency", cyc - exp_cyc_q.pop_front(), 6);
            end
        end
    end

    task automatic start_eval(input logic [W-1:0] xv);
        @(negedge clk);
        w = 1'b1;
        x = xv;
        @(negedge clk);
        w = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check(tag, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, n;
        int dc[$];
        rst = 1'b1; w = 1'b0; w0 = 1'b0; x = '0; x0 = '0;
        coef[0] = 8'd5; coef[1] = 8'd3; coef[2] = 8'd2;
        #1;
        check("rst_y", y, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_addr", coef_addr, 0);
        check("rst_y0", y0, 0);
        check("rst_busy0", busy0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic evaluation and coefficient read order
        start_eval(8'd4);
        a = cyc;
        check("t1_addr_load", coef_addr, 2);
        repeat (2) @(negedge clk);
        check("t1_addr_add1", coef_addr, 1);
        repeat (2) @(negedge clk);
        check("t1_addr_add0", coef_addr, 0);
        wait_done(10, "t1_timeout");
        check("t1_latency", cyc - a, 6);
        check("t1_y", y, 49);
        check("t1_ovf", ovf, 0);
        @(negedge clk);
        check("t1_done_width", done, 0);

        // Overflow path
        start_eval(8'd16);
        wait_done(10, "t2_timeout");
        check("t2_y", y, SAT ? 255 : 53);
        check("t2_ovf", ovf, SAT ? 1 : 0);

        // w held high: back-to-back evaluations
        @(negedge clk);
        w = 1'b1;
        a = cyc + 1;
        for (int i = 0; i < 26; i++) begin
            x = W'($urandom_range(0, 255));
            @(negedge clk);
            if (i == 19) w = 1'b0;
            if (done) dc.push_back(cyc);
        end
        check("t3_pulses", dc.size(), 3);
        if (dc.size() == 3) begin
            check("t3_first", dc[0] - a, 6);
            check("t3_gap1", dc[1] - dc[0], 7);
            check("t3_gap2", dc[2] - dc[1], 7);
        end

        // Asynchronous reset during the second MUL
        start_eval(8'd4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_y", y, 0);
        check("t4_done", done, 0);
        check("t4_busy", busy, 0);
        check("t4_ovf", ovf, 0);
        exp_q.delete();
        exp_ovf_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        start_eval(8'd4);
        wait_done(10, "t4_timeout");
        check("t4_y_after", y, 49);

        // x changed after acceptance
        start_eval(8'd4);
        x = 8'd9;
        wait_done(10, "t6_timeout");
        check("t6_y", y, 49);

        // DEGREE=0 instance
        @(negedge clk);
        w0 = 1'b1;
        x0 = W'($urandom_range(0, 255));
        @(negedge clk);
        w0 = 1'b0;
        a = cyc;
        check("t5_addr", coef_addr0, 0);
        n = 0;
        while (!done0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_done", done0, 1);
        check("t5_latency", cyc - a, 2);
        check("t5_y", y0, 8'h7A);
        check("t5_ovf", ovf0, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
